// File: rtl/guess_round_ctrl_if.sv
// Signal bundle between the guess-game round controller and its surroundings
// (switches, LFSR, score display and sound player).
interface guess_round_ctrl_if #(
  parameter int unsigned GuessW = 4,
  parameter int unsigned ScoreW = 5
);
  logic [1:0]        game_mode;
  logic              ready;
  logic              submit;
  logic [GuessW-1:0] user_guess;
  logic [GuessW-1:0] rand_value;
  logic              snd_ack;
  logic [ScoreW-1:0] user_correct;
  logic [ScoreW-1:0] user_incorrect;
  logic [ScoreW-1:0] round;
  logic              snd_req;
  logic              snd_val;
  logic              rand_load;
  logic              busy;
  logic              done;

  // The controller owns the game state; the environment supplies player and LFSR inputs.
  modport master (
    input  game_mode, ready, submit, user_guess, rand_value, snd_ack,
    output user_correct, user_incorrect, round, snd_req, snd_val, rand_load, busy, done
  );

  modport slave (
    output game_mode, ready, submit, user_guess, rand_value, snd_ack,
    input  user_correct, user_incorrect, round, snd_req, snd_val, rand_load, busy, done
  );
endinterface

// File: rtl/guess_round_ctrl.sv
// Round controller for the number-guessing game: timed rounds, radix-aware judgement,
// saturating scores, sound request handshake with timeout and LFSR advance pulses.
module guess_round_ctrl #(
  parameter int unsigned GuessW      = 4,
  parameter int unsigned ScoreW      = 5,
  parameter int unsigned Rounds      = 10,
  parameter int unsigned RoundCycles = 500_000_000,
  parameter int unsigned SndTo       = 50_000_000
) (
  input logic               clk_i,
  input logic               rst_i,
  guess_round_ctrl_if.master bus
);

  localparam int unsigned TimerW = (RoundCycles > 1) ? $clog2(RoundCycles) : 1;
  localparam int unsigned StoW   = (SndTo > 1) ? $clog2(SndTo) : 1;

  localparam logic [TimerW-1:0] TimerLast  = TimerW'(RoundCycles - 1);
  localparam logic [StoW-1:0]   StoLast    = StoW'(SndTo - 1);
  localparam logic [ScoreW-1:0] ScoreMax   = '1;
  localparam logic [ScoreW-1:0] RoundsLast = ScoreW'(Rounds);
  localparam logic [31:0]       DecLimit   = 32'd9;
  localparam logic [31:0]       OctLimit   = 32'd7;
  localparam logic [31:0]       HexLimit   = 32'((64'd1 << GuessW) - 64'd1);

  typedef enum logic [2:0] {StIdle, StPlay, StJudge, StSound, StDone} state_e;

  state_e            state_q;
  logic [1:0]        mode_q;
  logic [TimerW-1:0] timer_q;
  logic [StoW-1:0]   sto_q;
  logic [GuessW-1:0] guess_q;
  logic [GuessW-1:0] target_q;
  logic [ScoreW-1:0] correct_q, incorrect_q, round_q;
  logic [ScoreW-1:0] correct_d, incorrect_d, round_d;
  logic              snd_req_q, snd_val_q, rand_load_q, busy_q, done_q;
  logic [31:0]       limit;
  logic              hit;

  always_comb begin
    case (mode_q)
      2'b10:   limit = HexLimit;
      2'b11:   limit = OctLimit;
      default: limit = DecLimit;
    endcase
    hit         = (guess_q == target_q) && (32'(guess_q) <= limit);
    correct_d   = (hit && (correct_q != ScoreMax)) ? correct_q + ScoreW'(1) : correct_q;
    incorrect_d = (!hit && (incorrect_q != ScoreMax)) ? incorrect_q + ScoreW'(1) : incorrect_q;
    round_d     = (round_q != ScoreMax) ? round_q + ScoreW'(1) : round_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      mode_q      <= 2'b00;
      timer_q     <= '0;
      sto_q       <= '0;
      guess_q     <= '0;
      target_q    <= '0;
      correct_q   <= '0;
      incorrect_q <= '0;
      round_q     <= '0;
      snd_req_q   <= 1'b0;
      snd_val_q   <= 1'b0;
      rand_load_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rand_load_q <= 1'b0;
      // Dropping ready mid-game abandons the round; scores stay visible.
      if (!bus.ready && (state_q inside {StPlay, StJudge, StSound})) begin
        state_q   <= StIdle;
        snd_req_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          StIdle: begin
            if (bus.ready) begin
              correct_q   <= '0;
              incorrect_q <= '0;
              round_q     <= '0;
              timer_q     <= '0;
              mode_q      <= bus.game_mode;
              rand_load_q <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= StPlay;
            end
          end
          StPlay: begin
            if (bus.submit || (timer_q == TimerLast)) begin
              guess_q  <= bus.user_guess;
              target_q <= bus.rand_value;
              state_q  <= StJudge;
            end else begin
              timer_q <= timer_q + TimerW'(1);
            end
          end
          StJudge: begin
            correct_q   <= correct_d;
            incorrect_q <= incorrect_d;
            round_q     <= round_d;
            snd_req_q   <= 1'b1;
            snd_val_q   <= ~hit;
            sto_q       <= '0;
            state_q     <= StSound;
          end
          StSound: begin
            if (bus.snd_ack || (sto_q == StoLast)) begin
              snd_req_q <= 1'b0;
              if (round_q == RoundsLast) begin
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                timer_q     <= '0;
                rand_load_q <= 1'b1;
                state_q     <= StPlay;
              end
            end else begin
              sto_q <= sto_q + StoW'(1);
            end
          end
          StDone: begin
            if (!bus.ready) begin
              done_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.user_correct   = correct_q;
  assign bus.user_incorrect = incorrect_q;
  assign bus.round          = round_q;
  assign bus.snd_req        = snd_req_q;
  assign bus.snd_val        = snd_val_q;
  assign bus.rand_load      = rand_load_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;

endmodule
